// File: rtl/sw_btn_in.sv
// sw_btn_in: memory-mapped read-side input block for 16 switches and 5 push-buttons.
// Raw inputs are synchronised, debounced on a slow sample tick, and button rising
// edges are latched into write-1-to-clear PRESS flags. Three read registers:
//   0x0 SW[15:0], 0x4 BTN[4:0], 0x8 PRESS[4:0], 0xC reserved (reads 0).
module sw_btn_in #(
    parameter int unsigned SAMPLE_DIV = 100000,  // clk cycles per sample tick, >= 2
    parameter int unsigned DB_TICKS   = 3        // agreeing ticks before a bit flips, 1..7
) (
    input  logic        clk,
    input  logic        rst,    // asynchronous, active-low
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [31:0] rdata
);

    localparam int unsigned NumSw  = 16;
    localparam int unsigned NumBtn = 5;
    localparam int unsigned NumIn  = NumSw + NumBtn;
    localparam int unsigned DivW   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
    // cnt == DB_TICKS-1 is the same test as cnt+1 == DB_TICKS without widening cnt
    localparam logic [2:0]      DbLast  = 3'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        RegSw    = 2'd0,
        RegBtn   = 2'd1,
        RegPress = 2'd2,
        RegRsvd  = 2'd3
    } reg_sel_e;

    reg_sel_e reg_sel;
    assign reg_sel = reg_sel_e'(addr[3:2]);

    // Only addr[3:2] and wdata[4:0] carry meaning here
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:5]};

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [NumIn-1:0] raw_in;
    logic [NumIn-1:0] sync1_q;
    logic [NumIn-1:0] sync2_q;

    // Buttons occupy the top five bits so that the SW/BTN slices stay contiguous
    assign raw_in = {btn, sw};

    // Two-flop synchroniser for every asynchronous input bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [DivW-1:0] div_q;
    logic [DivW-1:0] div_d;
    logic            tick;

    // Free-running 0..SAMPLE_DIV-1 counter; tick marks the last count
    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + DivW'(1);
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce
    // ------------------------------------------------------------------
    logic [NumIn-1:0] stable;

    for (genvar i = 0; i < NumIn; i++) begin : gen_db
        logic       bit_q;
        logic       bit_d;
        logic [2:0] cnt_q;
        logic [2:0] cnt_d;

        // Count consecutive disagreeing ticks; any agreeing tick restarts the run
        always_comb begin
            bit_d = bit_q;
            cnt_d = cnt_q;
            if (tick) begin
                if (sync2_q[i] != bit_q) begin
                    if (cnt_q == DbLast) begin
                        bit_d = sync2_q[i];
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        end

        // Debounce state for this bit
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bit_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                bit_q <= bit_d;
                cnt_q <= cnt_d;
            end
        end

        assign stable[i] = bit_q;
    end

    logic [NumSw-1:0]  sw_db;
    logic [NumBtn-1:0] btn_db;

    assign sw_db  = stable[NumSw-1:0];
    assign btn_db = stable[NumIn-1:NumSw];

    // ------------------------------------------------------------------
    // Press latch
    // ------------------------------------------------------------------
    logic [NumBtn-1:0] btn_prev_q;
    logic [NumBtn-1:0] press_q;
    logic [NumBtn-1:0] press_d;
    logic [NumBtn-1:0] press_set;
    logic [NumBtn-1:0] press_clr;

    // Rising edge of the debounced button sets; W1C clears; set has priority
    always_comb begin
        press_set = btn_db & ~btn_prev_q;
        press_clr = (we && (reg_sel == RegPress)) ? wdata[NumBtn-1:0] : '0;
        press_d   = press_set | (press_q & ~press_clr);
    end

    // Previous debounced button level and sticky press flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev_q <= '0;
            press_q    <= '0;
        end else begin
            btn_prev_q <= btn_db;
            press_q    <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Zero-latency read of registered state; unused upper bits read 0
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegSw:    rdata[NumSw-1:0]  = sw_db;
            RegBtn:   rdata[NumBtn-1:0] = btn_db;
            RegPress: rdata[NumBtn-1:0] = press_q;
            RegRsvd:  rdata             = '0;
            default:  rdata             = '0;
        endcase
    end

endmodule

// File: tb/tb_sw_btn_in.sv
// Self-checking bench for sw_btn_in with SAMPLE_DIV=4, DB_TICKS=3.
module tb_sw_btn_in;

    localparam int unsigned SampleDiv = 4;
    localparam int unsigned DbTicks   = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] addr  = '0;
    logic        we    = 1'b0;
    logic [31:0] wdata = '0;
    logic [15:0] sw    = '0;
    logic [4:0]  btn   = '0;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    sw_btn_in #(
        .SAMPLE_DIV(SampleDiv),
        .DB_TICKS  (DbTicks)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .sw   (sw),
        .btn  (btn),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        wdata = '0;
    endtask

    // Poll a register once per cycle until it reads v or the budget runs out
    task automatic wait_rd(input logic [31:0] a, input logic [31:0] v, input int budget,
                           output int cycles, output logic [31:0] d);
        cycles = 0;
        rd(a, d);
        while (d !== v && cycles < budget) begin
            step();
            cycles++;
            rd(a, d);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        int cyc;
        rst = 1'b0;
        sw  = 16'hFFFF;
        btn = 5'h1F;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) $display("FAIL reset_read_%0d: got %h want %h", i, d, e);
            else n_pass++;
        end
        exp_q.push_back(32'h0000FFFF);
        exp_q.push_back(32'h0000001F);
        exp_q.push_back(32'h0000001F);
        step();
        rst = 1'b1;
        wait_rd(32'h0, 32'h0000FFFF, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL reset_sw_settle: got %h want %h", d, e);
        else n_pass++;
        n_checks++;
        if (cyc < 11 || cyc > 14) $display("FAIL reset_sw_latency: got %0d want 11..14", cyc);
        else n_pass++;
        rd(32'h4, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL reset_btn_settle: got %h want %h", d, e);
        else n_pass++;
        step();
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL reset_press_set: got %h want %h", d, e);
        else n_pass++;
        // Return to idle inputs with PRESS cleared
        sw  = '0;
        btn = '0;
        exp_q.push_back(32'h0);
        wait_rd(32'h0, 32'h0, 30, cyc, d);
        wait_rd(32'h4, 32'h0, 30, cyc, d);
        wr(32'h8, 32'h1F);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL reset_press_clear: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_debounce();
        logic [31:0] d, e;
        int cyc, bad;
        sw[3] = 1'b1;
        exp_q.push_back(32'h0);
        repeat (6) step();
        sw[3] = 1'b0;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            rd(32'h0, d);
            if (d !== 32'h0) bad++;
            step();
        end
        e = exp_q.pop_front();
        n_checks++;
        if (32'(bad) !== e) $display("FAIL glitch_filtered: got %0d nonzero reads want %0d", bad, e);
        else n_pass++;
        sw[3] = 1'b1;
        exp_q.push_back(32'h8);
        wait_rd(32'h0, 32'h8, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL debounce_hold: got %h want %h", d, e);
        else n_pass++;
        n_checks++;
        if (cyc < 11 || cyc > 14) $display("FAIL debounce_latency: got %0d want 11..14", cyc);
        else n_pass++;
        sw[3] = 1'b0;
        exp_q.push_back(32'h0);
        wait_rd(32'h0, 32'h0, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL debounce_release: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_press_latch();
        logic [31:0] d, e;
        int cyc;
        btn[2] = 1'b1;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        repeat (20) step();
        rd(32'h4, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL press_btn_high: got %h want %h", d, e);
        else n_pass++;
        btn[2] = 1'b0;
        wait_rd(32'h4, 32'h0, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL press_btn_low: got %h want %h", d, e);
        else n_pass++;
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL press_sticky: got %h want %h", d, e);
        else n_pass++;
        wr(32'h8, 32'h0);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL press_write0: got %h want %h", d, e);
        else n_pass++;
        wr(32'h8, 32'h4);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL press_w1c: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_set_clear_collision();
        logic [31:0] d, e;
        int cyc;
        btn[0] = 1'b1;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        // First cycle BTN reads 1 is the cycle the rising edge sets PRESS
        wait_rd(32'h4, 32'h1, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL collide_btn_rise: got %h want %h", d, e);
        else n_pass++;
        wr(32'h8, 32'h1);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL collide_set_wins: got %h want %h", d, e);
        else n_pass++;
        btn[0] = 1'b0;
        wait_rd(32'h4, 32'h0, 30, cyc, d);
        wr(32'h8, 32'h1);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL collide_cleanup: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d, e;
        int cyc;
        sw[0] = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        // Ten cycles after the edge cover exactly two ticks with the new level
        repeat (10) step();
        rd(32'h0, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL midrst_before: got %h want %h", d, e);
        else n_pass++;
        rst = 1'b0;
        rd(32'h0, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL midrst_during: got %h want %h", d, e);
        else n_pass++;
        step();
        step();
        rst = 1'b1;
        rd(32'h0, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL midrst_after: got %h want %h", d, e);
        else n_pass++;
        wait_rd(32'h0, 32'h1, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL midrst_settle: got %h want %h", d, e);
        else n_pass++;
        // Sync restarts at 0 and the prescaler at 0: ticks land on cycles 4, 8, 12
        n_checks++;
        if (cyc != 12) $display("FAIL midrst_latency: got %0d want 12", cyc);
        else n_pass++;
    endtask

    task automatic test_map_edges();
        logic [31:0] d, e;
        int cyc;
        btn[1] = 1'b1;
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h2);
        wait_rd(32'h4, 32'h2, 30, cyc, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL map_btn_rise: got %h want %h", d, e);
        else n_pass++;
        step();
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL map_press_set: got %h want %h", d, e);
        else n_pass++;
        wr(32'h0, 32'hFFFF_FFFF);
        wr(32'h4, 32'hFFFF_FFFF);
        wr(32'hC, 32'hFFFF_FFFF);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) $display("FAIL map_read_%0d: got %h want %h", i, d, e);
            else n_pass++;
        end
        exp_q.push_back(32'h0);
        wr(32'h8, 32'hFFFF_FFFF);
        rd(32'h8, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) $display("FAIL map_press_w1c_all: got %h want %h", d, e);
        else n_pass++;
    endtask

    initial begin
        #2;
        test_reset();
        test_debounce();
        test_press_latch();
        test_set_clear_collision();
        test_reset_mid_debounce();
        test_map_edges();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
